// File: rtl/keypad_scanner_pkg.sv
// Shared key-code constants for the keypad scanner and the RPN stack,
// plus the scanner state type and the row/column to key-code map.
package keypad_scanner_pkg;

  localparam logic [4:0] KEY_0     = 5'b00000;
  localparam logic [4:0] KEY_1     = 5'b00001;
  localparam logic [4:0] KEY_2     = 5'b00010;
  localparam logic [4:0] KEY_3     = 5'b00011;
  localparam logic [4:0] KEY_4     = 5'b00100;
  localparam logic [4:0] KEY_5     = 5'b00101;
  localparam logic [4:0] KEY_6     = 5'b00110;
  localparam logic [4:0] KEY_7     = 5'b00111;
  localparam logic [4:0] KEY_8     = 5'b01000;
  localparam logic [4:0] KEY_9     = 5'b01001;
  localparam logic [4:0] KEY_PLUS  = 5'b10000;
  localparam logic [4:0] KEY_MINUS = 5'b10001;
  localparam logic [4:0] KEY_BACKS = 5'b10010;
  localparam logic [4:0] KEY_ENTER = 5'b10011;
  localparam logic [4:0] KEY_UP    = 5'b10100;
  localparam logic [4:0] KEY_DOWN  = 5'b10101;
  localparam logic [4:0] KEY_NOP   = 5'b10110;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_e;

  // Physical keypad layout: rows top to bottom, columns left to right.
  function automatic logic [4:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [4:0] code;
    code = KEY_NOP;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_PLUS;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_MINUS;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_BACKS;
      4'b11_00: code = KEY_UP;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_DOWN;
      4'b11_11: code = KEY_ENTER;
      default:  code = KEY_NOP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Parameterized-width two-flop synchronizer. Resets to all ones so that
// pulled-up (idle) inputs read as "nothing pressed" straight out of reset.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops to settle the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, samples the
// synchronized rows once per column slot, debounces presses and releases,
// and reports the accepted key code with an intro level held while pressed.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [4:0] key_code,
  output logic       intro
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]    w_rows_s;
  logic [3:0]    w_low;
  logic          w_one_low;
  logic [1:0]    w_row_idx;
  logic [4:0]    w_cand_code;
  logic          w_latched_present;
  logic          w_sample;
  logic [DW-1:0] w_deb_nxt;
  logic          w_deb_done;

  logic [CW-1:0] r_cnt;
  scan_state_e   r_state;
  logic [1:0]    r_col;
  logic [DW-1:0] r_deb_cnt;
  logic [1:0]    r_cand_row;
  logic [4:0]    r_cand_code;
  logic [4:0]    r_key_code;
  logic          r_intro;

  sync2 #(.WIDTH(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .i_d (row_in),
    .o_q (w_rows_s)
  );

  // Exactly one low row is a real key; none or several is rejected as ghosting.
  assign w_low       = ~w_rows_s;
  assign w_one_low   = $onehot(w_low);
  assign w_cand_code = key_lookup(w_row_idx, r_col);
  assign w_latched_present = w_low[r_cand_row];
  assign w_sample    = (r_cnt == CW'(SCAN_DIV - 1));
  assign w_deb_nxt   = r_deb_cnt + DW'(1);
  assign w_deb_done  = (w_deb_nxt == DW'(DEBOUNCE_SCANS));

  // Index of the low row (meaningful only when exactly one row is low).
  always_comb begin
    w_row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_low[i]) w_row_idx = 2'(i);
    end
  end

  // Column slot timer; the last count of each slot is the sample point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_sample) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Scan/debounce FSM; the column stays frozen while a key is being tracked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SCAN;
      r_col       <= 2'd0;
      r_deb_cnt   <= '0;
      r_cand_row  <= 2'd0;
      r_cand_code <= KEY_NOP;
      r_key_code  <= KEY_NOP;
      r_intro     <= 1'b0;
    end else if (w_sample) begin
      case (r_state)
        ST_SCAN: begin
          if (w_one_low) begin
            r_cand_row  <= w_row_idx;
            r_cand_code <= w_cand_code;
            if (DEBOUNCE_SCANS == 1) begin
              r_state    <= ST_HELD;
              r_key_code <= w_cand_code;
              r_intro    <= 1'b1;
              r_deb_cnt  <= '0;
            end else begin
              r_state   <= ST_DEBOUNCE;
              r_deb_cnt <= DW'(1);
            end
          end else begin
            r_col <= r_col + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (w_one_low && (w_cand_code == r_cand_code)) begin
            if (w_deb_done) begin
              r_state    <= ST_HELD;
              r_key_code <= r_cand_code;
              r_intro    <= 1'b1;
              r_deb_cnt  <= '0;
            end else begin
              r_deb_cnt <= w_deb_nxt;
            end
          end else begin
            r_state   <= ST_SCAN;
            r_deb_cnt <= '0;
            r_col     <= r_col + 2'd1;
          end
        end
        ST_HELD: begin
          // Only the latched row matters; other keys on this column are ignored.
          if (!w_latched_present) begin
            if (DEBOUNCE_SCANS == 1) begin
              r_state <= ST_SCAN;
              r_intro <= 1'b0;
              r_col   <= r_col + 2'd1;
            end else begin
              r_state   <= ST_RELEASE;
              r_deb_cnt <= DW'(1);
            end
          end
        end
        ST_RELEASE: begin
          if (w_latched_present) begin
            r_state   <= ST_HELD;
            r_deb_cnt <= '0;
          end else if (w_deb_done) begin
            r_state   <= ST_SCAN;
            r_intro   <= 1'b0;
            r_deb_cnt <= '0;
            r_col     <= r_col + 2'd1;
          end else begin
            r_deb_cnt <= w_deb_nxt;
          end
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  assign col_out  = ~(4'b0001 << r_col);
  assign key_code = r_key_code;
  assign intro    = r_intro;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A keypad model turns pressed keys into row levels from the driven column;
// expected key codes are queued when a press is applied and popped on each
// intro rising edge.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  localparam int SD = 4;
  localparam int DS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [4:0] key_code;
  logic       intro;

  logic [3:0][3:0] key_dn = '0;  // [row][col]
  logic [4:0]      exp_q[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  int              rise_cnt = 0;
  int              fall_cnt = 0;
  logic            intro_q = 1'b0;

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .intro    (intro)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_dn[r][c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic ticks(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_intro(input logic lvl, input int budget, input string tag, output int n);
    n = 0;
    while (intro !== lvl && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, intro, lvl);
  endtask

  // Scoreboard: every intro rising edge must match the oldest queued key.
  initial begin
    forever begin
      @(negedge clk);
      if (intro === 1'b1 && intro_q === 1'b0) begin
        rise_cnt++;
        chk("sb_pending", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("key_code", key_code, exp_q.pop_front());
      end
      if (intro === 1'b0 && intro_q === 1'b1) fall_cnt++;
      intro_q = intro;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         r0;
    int         f0;
    logic [3:0] e_col;
    logic [3:0] seen;

    // Reset values
    rst = 1'b1;
    ticks(3);
    chk("rst_col", col_out, 4'b1110);
    chk("rst_code", key_code, KEY_NOP);
    chk("rst_intro", intro, 0);
    rst = 1'b0;

    // Idle scanning: each column stays low for SD clocks, rotating 0..3
    e_col = 4'b1110;
    ticks(2);
    for (int k = 0; k < 8; k++) begin
      chk("col_rot", col_out, e_col);
      e_col = {e_col[2:0], e_col[3]};
      ticks(4);
    end

    // Key 5 held 40 cycles: one edge, then release after DS absent samples
    key_dn[1][1] = 1'b1;
    exp_q.push_back(KEY_5);
    wait_intro(1'b1, 200, "k5_press", n);
    ticks(1);
    r0 = rise_cnt;
    f0 = fall_cnt;
    ticks(40);
    chk("k5_hold", intro, 1);
    chk("k5_no_fall", fall_cnt - f0, 0);
    chk("k5_one_rise", rise_cnt - r0, 0);
    key_dn[1][1] = 1'b0;
    wait_intro(1'b0, 100, "k5_release", n);
    // first absent sample 3..6 clocks after release (sync + slot phase), drop 2 slots later
    chk("k5_rel_lat", (n >= 11 && n <= 14), 1);
    chk("k5_code_kept", key_code, KEY_5);

    // ENTER bouncing every 3 clocks for 12 clocks, then stable
    ticks(10);
    r0 = rise_cnt;
    for (int i = 0; i < 4; i++) begin
      key_dn[3][3] = ~key_dn[3][3];
      ticks(3);
    end
    chk("bounce_quiet", rise_cnt - r0, 0);
    chk("bounce_intro", intro, 0);
    key_dn[3][3] = 1'b1;
    exp_q.push_back(KEY_ENTER);
    wait_intro(1'b1, 300, "enter_press", n);
    ticks(2);
    key_dn[3][3] = 1'b0;
    wait_intro(1'b0, 100, "enter_release", n);

    // Two rows on column 3 together: rejected, scanning continues
    ticks(10);
    r0 = rise_cnt;
    key_dn[0][3] = 1'b1;
    key_dn[2][3] = 1'b1;
    seen = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      ticks(1);
      seen |= ~col_out;
    end
    chk("ghost_cols", seen, 4'b1111);
    chk("ghost_quiet", rise_cnt - r0, 0);
    chk("ghost_intro", intro, 0);
    key_dn[2][3] = 1'b0;
    exp_q.push_back(KEY_PLUS);
    wait_intro(1'b1, 200, "plus_press", n);
    ticks(2);
    key_dn[0][3] = 1'b0;
    wait_intro(1'b0, 100, "plus_release", n);

    // Key 7 with a release glitch covering exactly one sample point
    ticks(10);
    key_dn[2][0] = 1'b1;
    exp_q.push_back(KEY_7);
    wait_intro(1'b1, 200, "k7_press", n);
    ticks(6);
    r0 = rise_cnt;
    f0 = fall_cnt;
    key_dn[2][0] = 1'b0;
    ticks(SD);
    key_dn[2][0] = 1'b1;
    ticks(20);
    chk("glitch_held", intro, 1);
    chk("glitch_no_fall", fall_cnt - f0, 0);
    chk("glitch_no_rise", rise_cnt - r0, 0);
    key_dn[2][0] = 1'b0;
    wait_intro(1'b0, 100, "k7_release", n);
    ticks(4);
    key_dn[3][1] = 1'b1;
    exp_q.push_back(KEY_0);
    wait_intro(1'b1, 200, "k0_press", n);
    ticks(2);
    key_dn[3][1] = 1'b0;
    wait_intro(1'b0, 100, "k0_release", n);

    // Reset pulse while key 9 is held, then re-acceptance of the same key
    ticks(10);
    key_dn[2][2] = 1'b1;
    exp_q.push_back(KEY_9);
    wait_intro(1'b1, 200, "k9_press", n);
    ticks(5);
    rst = 1'b1;
    ticks(1);
    chk("rst_mid_intro", intro, 0);
    chk("rst_mid_code", key_code, KEY_NOP);
    chk("rst_mid_col", col_out, 4'b1110);
    rst = 1'b0;
    exp_q.push_back(KEY_9);
    n = 0;
    while (col_out !== 4'b1011 && n < 100) begin
      ticks(1);
      n++;
    end
    chk("reach_col2", col_out, 4'b1011);
    n = 0;
    while (intro !== 1'b1 && n < 100) begin
      ticks(1);
      n++;
    end
    // one slot to the first sample on column 2, then (DS-1) slots of debounce
    chk("k9_relatch_lat", n, SD + (DS - 1) * SD);
    ticks(2);
    key_dn[2][2] = 1'b0;
    wait_intro(1'b0, 100, "k9_release", n);

    ticks(4);
    chk("rises", rise_cnt, 7);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
